// File: rtl/apb_event_master_pkg.sv
// rtl/apb_event_master_pkg.sv - shared types for the APB event master
package apb_event_master_pkg;

    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_MAX_ADDR_WIDTH = 32;

    // Transfer phases of the single-outstanding APB initiator
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Request as seen by agents; the address field is sized for the widest bus
    typedef struct packed {
        logic                          write;
        logic [APB_MAX_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0]     wdata;
    } req_t;

    // Completion record handed back on the response channel
    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } rsp_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - counts stalled ACCESS cycles and flags expiry
module apb_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is the LIMIT-th stalled cycle: the count before this cycle is LIMIT-1
    assign expired_o = (LIMIT != 0) && enable_i && (cnt_q == LAST);

    // Count stalled cycles; saturate at LAST so the counter can never wrap
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (LIMIT != 0) && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_event_master.sv
// rtl/apb_event_master.sv - valid/ready request to single APB3 transfer initiator
module apb_event_master
    import apb_event_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    rsp_t                      rsp_q, rsp_d;
    logic                      cnt_clear;
    logic                      cnt_enable;
    logic                      cnt_expired;

    apb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (HCLK),
        .rst       (HRESET),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_enable),
        .expired_o (cnt_expired)
    );

    // Bus strobes and handshakes are pure decodes of the state register
    assign req_ready_o   = (state_q == IDLE);
    assign PSEL          = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE       = (state_q == ACCESS);
    assign rsp_valid_o   = (state_q == RESP);
    assign PADDR         = paddr_q;
    assign PWDATA        = pwdata_q;
    assign PWRITE        = pwrite_q;
    assign rsp_rdata_o   = rsp_q.rdata;
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;

    // Next-state, request capture and response capture
    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        rsp_d      = rsp_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    paddr_d   = req_addr_i;
                    pwdata_d  = req_wdata_i;
                    pwrite_d  = req_write_i;
                    cnt_clear = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over an expiring counter in the same cycle
                if (PREADY) begin
                    rsp_d.rdata   = pwrite_q ? 32'd0 : PRDATA;
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_enable = 1'b1;
                    if (cnt_expired) begin
                        rsp_d.rdata   = 32'd0;
                        rsp_d.err     = 1'b1;
                        rsp_d.timeout = 1'b1;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, bus-side and response registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rsp_q    <= rsp_d;
        end
    end

endmodule

// File: doc/apb_event_master.md
Name: apb_event_master

Overview:
APB3 initiator that turns a single-outstanding valid/ready request into one APB read or write transfer. It returns the result on a valid/ready response channel. It is the bus-side counterpart of the event/service unit register slaves: firmware-less agents (DMA sequencers, event routers) use it to program ENABLE/SET/CLEAR registers and poll PENDING. It supports slave wait states, PSLVERR reporting and a configurable access timeout.

Parameters:
APB_ADDR_WIDTH, 12, width of PADDR and req_addr_i.
TIMEOUT_CYCLES, 255, maximum ACCESS cycles with PREADY low before abort; 0 disables timeout.

Ports:
HCLK  in  1  clock, all logic on rising edge.
HRESET  in  1  synchronous active-high reset.
req_valid_i  in  1  request present.
req_ready_o  out  1  request accepted when high with req_valid_i.
req_write_i  in  1  1 = write, 0 = read.
req_addr_i  in  APB_ADDR_WIDTH  byte address.
req_wdata_i  in  32  write data.
rsp_valid_o  out  1  response present.
rsp_ready_i  in  1  response consumed.
rsp_rdata_o  out  32  read data (0 for writes and aborted transfers).
rsp_err_o  out  1  PSLVERR seen or timeout.
rsp_timeout_o  out  1  transfer aborted by timeout.
PADDR  out  APB_ADDR_WIDTH  APB address.
PWDATA  out  32  APB write data.
PWRITE  out  1  APB direction.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PRDATA  in  32  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB slave error.

Behaviour:
- Reset: HCLK only, synchronous active-high HRESET. Reset sampled high at an edge forces the following values after that edge: state IDLE; PSEL, PENABLE, PWRITE, rsp_valid_o, rsp_err_o and rsp_timeout_o = 0; PADDR, PWDATA and rsp_rdata_o = 0; timeout counter 0. Reset mid-transfer drops PSEL/PENABLE immediately. No response is produced for the abandoned transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- req_ready_o = (state == IDLE), combinational from state only.
- IDLE: on req_valid_i && req_ready_o, register addr/wdata/write into PADDR/PWDATA/PWRITE and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Go unconditionally to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWDATA/PWRITE are stable from SETUP until ACCESS exits.
  - If PREADY=1: capture rsp_rdata_o = PWRITE ? 0 : PRDATA, rsp_err_o = PSLVERR, rsp_timeout_o = 0; go to RESP.
  - If PREADY=0: increment the timeout counter. When the counter equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), go to RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - PREADY=1 in the same cycle the counter would expire: completion wins, no timeout.
- RESP: PSEL=0, PENABLE=0, rsp_valid_o=1. Response fields are held stable until rsp_ready_i. On rsp_valid_o && rsp_ready_i go to IDLE and clear the counter.
- Latency: request accepted at edge N; SETUP in cycle N+1; ACCESS in N+2. With zero wait states, rsp_valid_o is high in N+3; each wait state adds one cycle. Minimum request-to-request spacing is 4 cycles.
- PADDR/PWDATA/PWRITE keep their last values in IDLE/RESP; PSEL=0 qualifies them.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It never wraps: it is cleared on entry to SETUP.
- PSLVERR is ignored unless PSEL && PENABLE && PREADY.
- rsp_err_o, rsp_timeout_o and rsp_rdata_o are registered, with no combinational path from the APB inputs.

Decomposition:
- Package apb_event_master_pkg: state enum (IDLE, SETUP, ACCESS, RESP), a request struct {write, addr, wdata} and a response struct {rdata, err, timeout}. Address width is passed via parameter.
- One natural sub-module, apb_timeout_counter: inputs clear/enable, parameter LIMIT, output expired.
- Everything else stays in a single FSM module.

Test Plan:
- Write addr 0x004, wdata 0xDEADBEEF, PREADY tied 1 -> PSEL high at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_rdata=0, rsp_err=0.
- Read addr 0x008, slave holds PREADY low 3 cycles then returns 0x0000_00A5 -> PADDR stable 5 cycles, rsp_rdata=0x0000_00A5 at N+6.
- Write with PSLVERR=1 on the PREADY cycle -> rsp_err=1, rsp_timeout=0; next request is accepted normally.
- TIMEOUT_CYCLES=4, PREADY never high -> exactly 4 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. With PREADY=1 on the 4th ACCESS cycle -> normal completion instead.
- rsp_ready_i held low 10 cycles -> response fields constant, req_ready_o=0, PSEL=0 throughout; handshake returns to IDLE.
- HRESET asserted for one cycle during ACCESS -> PSEL/PENABLE 0 at the next edge, no rsp_valid, req_ready_o=1 after reset deasserts.
